cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/cache_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cache_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared FSM state type and default sizing for the cache request arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 48;
  localparam int STATS_W     = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request above last_grant, wrapping.
module rr_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] index,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates NUM_REQ requesters onto one cache core port with a WAIT timeout.
// Optional per-requester and timeout statistics when CACHE_ARB_STATS_EN is defined.
module cache_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]          req_write,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_hit,
  output logic                        rsp_err,
  output logic                        cache_start,
  output logic [ADDR_W-1:0]           cache_addr,
  output logic                        cache_write,
  input  logic                        cache_done,
  input  logic                        cache_hit,
  output logic                        busy,
`ifdef CACHE_ARB_STATS_EN
  output logic [NUM_REQ*STATS_W-1:0]  grant_count,
  output logic [STATS_W-1:0]          timeout_count,
`endif
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  last_grant;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_last;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [ADDR_W-1:0]  win_addr;

  logic accept, wait_done, wait_tmo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .index      (arb_idx),
    .any        (arb_any)
  );

  assign win_addr  = req_addr[arb_idx*ADDR_W +: ADDR_W];
  assign wait_last = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    wait_done = 1'b0;
    wait_tmo  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A completion on the final WAIT cycle wins over the timeout.
        if (cache_done) begin
          wait_done = 1'b1;
          state_nxt = RESP;
        end else if (wait_last) begin
          wait_tmo  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) begin
      rsp_valid[grant_id] = 1'b1;
    end
  end

  assign cache_start = (state == ISSUE);
  assign busy        = (state != IDLE);

  // Transaction context: captured on accept, held until the next accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cache_addr  <= '0;
      cache_write <= 1'b0;
      grant_id    <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      wait_cnt    <= '0;
      rsp_hit     <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      if (accept) begin
        cache_addr  <= win_addr;
        cache_write <= req_write[arb_idx];
        grant_id    <= arb_idx;
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_done) begin
        rsp_hit <= cache_hit;
        rsp_err <= 1'b0;
      end else if (wait_tmo) begin
        rsp_hit <= 1'b0;
        rsp_err <= 1'b1;
      end
      if (state == RESP) begin
        last_grant <= grant_id;
      end
    end
  end

`ifdef CACHE_ARB_STATS_EN
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STATS_W-1:0] gcnt [NUM_REQ];
  logic [STATS_W-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt[i] <= '0;
      tcnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && (arb_idx == IDX_W'(i))) gcnt[i] <= sat_inc(gcnt[i]);
      end
      if (wait_tmo) tcnt <= sat_inc(tcnt);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    assign grant_count[g*STATS_W +: STATS_W] = gcnt[g];
  end
  assign timeout_count = tcnt;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed + randomized transaction bench for cache_arbiter with a transaction-level model.
module tb_cache_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 48;
  localparam int TMO = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR-1:0]     req_write = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_hit, rsp_err, cache_start, cache_write, busy;
  logic [AW-1:0]     cache_addr;
  logic              cache_done = 1'b0;
  logic              cache_hit = 1'b0;
  logic [1:0]        grant_id;
`ifdef CACHE_ARB_STATS_EN
  logic [NR*16-1:0]  grant_count;
  logic [15:0]       timeout_count;
`endif

  cache_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_write     (req_write),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_hit       (rsp_hit),
    .rsp_err       (rsp_err),
    .cache_start   (cache_start),
    .cache_addr    (cache_addr),
    .cache_write   (cache_write),
    .cache_done    (cache_done),
    .cache_hit     (cache_hit),
    .busy          (busy),
`ifdef CACHE_ARB_STATS_EN
    .grant_count   (grant_count),
    .timeout_count (timeout_count),
`endif
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Model state: who was served last and how many grants/timeouts since reset.
  int m_last = NR - 1;
  int m_gcnt [NR];
  int m_tmo = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input int last, input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++) begin
      if (m[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NR - 1;
    m_tmo  = 0;
    for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
  endtask

  // dly = WAIT cycle (1-based) carrying cache_done; 0 means the core never answers.
  task automatic run_txn(input logic [NR-1:0] mask, input int dly, input logic hit,
                         input logic stray, input logic fixed);
    logic [AW-1:0] addrs [NR];
    logic [NR-1:0] wr;
    int w, limit;
    for (int i = 0; i < NR; i++) begin
      addrs[i] = fixed ? AW'(48'h1000 * (i + 1)) : {16'($urandom), 32'($urandom)};
      req_addr[i*AW +: AW] = addrs[i];
    end
    wr = NR'($urandom);
    req_write = wr;
    req_valid = mask;
    #1;
    w = model_pick(m_last, mask);
    check("idle_busy", busy, 0);
    check("req_ready", req_ready, 64'(1) << w);
    tick();
    req_valid  = '0;
    cache_done = stray;
    cache_hit  = 1'b1;
    check("issue_start", cache_start, 1);
    check("grant_id", grant_id, w);
    check("cache_addr", cache_addr, addrs[w]);
    check("cache_write", cache_write, wr[w]);
    check("issue_ready", req_ready, 0);
    tick();
    cache_done = 1'b0;
    limit = (dly == 0) ? TMO : dly;
    for (int c = 1; c <= limit; c++) begin
      if (c == dly) begin
        cache_done = 1'b1;
        cache_hit  = hit;
      end
      if (c == 1) check("wait_start_low", cache_start, 0);
      if (c == limit) begin
        check("wait_no_rsp", rsp_valid, 0);
        check("wait_addr_hold", cache_addr, addrs[w]);
      end
      tick();
    end
    cache_done = stray;
    check("rsp_valid", rsp_valid, 64'(1) << w);
    check("rsp_hit", rsp_hit, (dly != 0) ? hit : 1'b0);
    check("rsp_err", rsp_err, (dly == 0) ? 1 : 0);
    check("resp_addr_hold", cache_addr, addrs[w]);
    check("resp_write_hold", cache_write, wr[w]);
    m_last = w;
    m_gcnt[w]++;
    if (dly == 0) m_tmo++;
    tick();
    cache_done = 1'b0;
    check("post_busy", busy, 0);
    check("post_rsp", rsp_valid, 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_ARB_STATS_EN
    check({tag, "_tmo_cnt"}, timeout_count, m_tmo);
    for (int i = 0; i < NR; i++) check({tag, "_gnt_cnt"}, grant_count[i*16 +: 16], m_gcnt[i]);
`else
    check({tag, "_idle"}, busy, 0);
`endif
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_start", cache_start, 0);
    check("rst_addr", cache_addr, 0);
    check("rst_write", cache_write, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_hit", rsp_hit, 0);
    check("rst_err", rsp_err, 0);
    check("rst_ready", req_ready, 0);
    reset = 1'b1;
    tick();
    check_stats("rst");

    // Fairness from reset: all requesters held high.
    for (int t = 0; t < 8; t++) begin
      check("fair_order", 64'(model_pick(m_last, 4'b1111)), 64'(t % NR));
      run_txn(4'b1111, $urandom_range(1, 6), 1'($urandom), 1'b0, 1'b0);
    end

    // Single request, done three cycles after start.
    run_txn(4'b0001, 3, 1'b1, 1'b0, 1'b1);

    // Timeout, then done/timeout collision on the last WAIT cycle.
    run_txn(4'b0100, 0, 1'b1, 1'b0, 1'b0);
    check_stats("after_tmo");
    run_txn(4'b1000, TMO, 1'b1, 1'b0, 1'b0);
    run_txn(4'b0010, TMO, 1'b0, 1'b1, 1'b0);

    // Stray completion while idle.
    req_valid  = '0;
    cache_done = 1'b1;
    cache_hit  = 1'b1;
    tick();
    cache_done = 1'b0;
    check("stray_busy", busy, 0);
    check("stray_rsp", rsp_valid, 0);
    check("stray_start", cache_start, 0);

    // Randomized traffic with partial masks and stray completions.
    for (int t = 0; t < 24; t++) begin
      run_txn(NR'($urandom_range(1, 15)), $urandom_range(1, 12), 1'($urandom),
              1'($urandom), 1'b0);
    end
    check_stats("random");

    // Reset in the middle of WAIT, then a stale completion.
    req_valid = 4'b0110;
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_rsp", rsp_valid, 0);
    check("midrst_grant_id", grant_id, 0);
    cache_done = 1'b1;
    cache_hit  = 1'b1;
    tick();
    cache_done = 1'b0;
    check("stale_busy", busy, 0);
    check("stale_rsp", rsp_valid, 0);
    check("stale_start", cache_start, 0);
    run_txn(4'b1111, 2, 1'b1, 1'b0, 1'b0);
    check("midrst_next_grant", grant_id, 0);
    check_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
